// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and defaults for the decode-stage hazard controller.
// Holds the multi-cycle FSM state enum, the reset fetch PC and the register index type.
package pipe_pkg;

  localparam int unsigned REG_AW_DEF   = 5;
  localparam logic [31:0] RESET_PC_DEF = 32'hbfc00000;

  typedef logic [REG_AW_DEF-1:0] reg_idx_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } mc_state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Handshake bundle between the hazard controller (master) and the
// multi-cycle unit (slave, e.g. the divider).
interface pipe_hazard_ctrl_if;
  logic mc_valid;
  logic mc_ready;
  logic mc_done;
  logic mc_discard;

  modport master (output mc_valid, output mc_discard, input mc_ready, input mc_done);
  modport slave  (input mc_valid, input mc_discard, output mc_ready, output mc_done);
endinterface

// File: rtl/pipe_hazard_ctrl_fwd_mux.sv
// Per-read-port forwarding select: finds the youngest downstream stage
// writing the register this port reads and returns its value plus a late flag.
module fwd_mux
  import pipe_pkg::*;
#(
  parameter int NUM_STAGES = 4,
  parameter int DATA_W     = 32,
  parameter int REG_AW     = 5
) (
  input  logic                         rd_en,
  input  logic [REG_AW-1:0]            rd_idx,
  input  logic [DATA_W-1:0]            rf_data,
  input  logic [NUM_STAGES-1:0]        stg_valid,
  input  logic [NUM_STAGES*REG_AW-1:0] stg_dest,
  input  logic [NUM_STAGES*DATA_W-1:0] stg_value,
  input  logic [NUM_STAGES-1:0]        stg_late,
  output logic [DATA_W-1:0]            data,
  output logic                         late,
  output logic                         hit
);

  logic [NUM_STAGES-1:0] match_s;

  // Hazard match per stage; r0 never hazards since it is hard-wired to zero.
  always_comb begin
    match_s = '0;
    for (int s = 0; s < NUM_STAGES; s++) begin
      match_s[s] = rd_en && (rd_idx != '0) && stg_valid[s] &&
                   (stg_dest[s*REG_AW +: REG_AW] == rd_idx);
    end
  end

  // Walk from oldest to youngest so the lowest matching stage wins last.
  always_comb begin
    data = rf_data;
    late = 1'b0;
    for (int s = NUM_STAGES - 1; s >= 0; s--) begin
      data = match_s[s] ? stg_value[s*DATA_W +: DATA_W] : data;
      late = match_s[s] ? stg_late[s] : late;
    end
    hit = |match_s;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Decode-stage hazard, forwarding and redirect controller.
// Optional performance counters are enabled by defining PIPE_HAZ_PERF_EN.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int          NUM_STAGES = 4,
  parameter int          NUM_RPORTS = 2,
  parameter int          DATA_W     = 32,
  parameter int          REG_AW     = 5,
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         de_valid,
  input  logic [NUM_RPORTS-1:0]        de_rd_en,
  input  logic [NUM_RPORTS*REG_AW-1:0] de_rd_idx,
  input  logic [NUM_RPORTS*DATA_W-1:0] rf_rdata,
  output logic [NUM_RPORTS*DATA_W-1:0] fwd_rdata,
  input  logic [NUM_STAGES-1:0]        stg_valid,
  input  logic [NUM_STAGES*REG_AW-1:0] stg_dest,
  input  logic [NUM_STAGES*DATA_W-1:0] stg_value,
  input  logic [NUM_STAGES-1:0]        stg_late,
  input  logic                         de_mc_req,
  pipe_hazard_ctrl_if.master           mc,
  output logic                         de_stall,
  output logic                         flush,
  input  logic                         exc_valid,
  input  logic [31:0]                  exc_target,
  input  logic                         eret_valid,
  input  logic [31:0]                  eret_target,
  input  logic                         br_valid,
  input  logic [31:0]                  br_target,
  input  logic                         fe_valid,
  input  logic [31:0]                  fe_pc,
  output logic [31:0]                  nextpc
`ifdef PIPE_HAZ_PERF_EN
  ,
  output logic [31:0]                  perf_stall_cnt,
  output logic [31:0]                  perf_fwd_cnt
`endif
);

  logic [NUM_RPORTS-1:0] late_s;
  logic [NUM_RPORTS-1:0] hit_s;
  logic                  flush_s;
  logic                  mc_valid_s;
  logic                  mc_discard_s;
  logic                  mc_stall_s;
  logic                  de_stall_s;
  mc_state_t             state_d, state_q;
  logic [31:0]           nextpc_d, nextpc_q;

  for (genvar p = 0; p < NUM_RPORTS; p++) begin : g_port
    fwd_mux #(
      .NUM_STAGES (NUM_STAGES),
      .DATA_W     (DATA_W),
      .REG_AW     (REG_AW)
    ) u_fwd_mux (
      .rd_en     (de_rd_en[p]),
      .rd_idx    (de_rd_idx[p*REG_AW +: REG_AW]),
      .rf_data   (rf_rdata[p*DATA_W +: DATA_W]),
      .stg_valid (stg_valid),
      .stg_dest  (stg_dest),
      .stg_value (stg_value),
      .stg_late  (stg_late),
      .data      (fwd_rdata[p*DATA_W +: DATA_W]),
      .late      (late_s[p]),
      .hit       (hit_s[p])
    );
  end

  // Multi-cycle unit FSM: next state, issue strobe, discard and stall request.
  always_comb begin
    flush_s      = exc_valid || eret_valid;
    state_d      = state_q;
    mc_valid_s   = 1'b0;
    mc_discard_s = 1'b0;
    mc_stall_s   = 1'b0;
    case (state_q)
      IDLE: begin
        mc_valid_s = de_valid && de_mc_req && !flush_s;
        if (mc_valid_s && mc.mc_ready) begin
          state_d = WAIT;
        end else begin
          mc_stall_s = mc_valid_s;
        end
      end
      WAIT: begin
        // A result arriving with a flush still belongs to a committed op.
        mc_stall_s = 1'b1;
        if (mc.mc_done) begin
          state_d = IDLE;
        end else if (flush_s) begin
          state_d = DRAIN;
        end else begin
          state_d = WAIT;
        end
      end
      DRAIN: begin
        mc_discard_s = mc.mc_done;
        mc_stall_s   = de_valid && de_mc_req;
        if (mc.mc_done) begin
          state_d = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Combine hazard and unit stalls, then pick the next fetch PC by priority.
  always_comb begin
    de_stall_s = (|late_s) || mc_stall_s;
    if (exc_valid) begin
      nextpc_d = exc_target;
    end else if (eret_valid) begin
      nextpc_d = eret_target;
    end else if (de_valid && br_valid && !de_stall_s) begin
      nextpc_d = br_target;
    end else if (!fe_valid) begin
      nextpc_d = RESET_PC;
    end else begin
      nextpc_d = fe_pc + 32'd4;
    end
  end

  // State and fetch PC registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      nextpc_q <= RESET_PC;
    end else begin
      state_q  <= state_d;
      nextpc_q <= nextpc_d;
    end
  end

  assign mc.mc_valid   = mc_valid_s;
  assign mc.mc_discard = mc_discard_s;
  assign de_stall      = de_stall_s;
  assign flush         = flush_s;
  assign nextpc        = nextpc_q;

`ifdef PIPE_HAZ_PERF_EN
  logic [31:0] perf_stall_d, perf_stall_q;
  logic [31:0] perf_fwd_d, perf_fwd_q;

  // Saturating event counters for stalled decode cycles and forwarding cycles.
  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_fwd_d   = perf_fwd_q;
    if (de_valid && de_stall_s && (perf_stall_q != 32'hffffffff)) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end else begin
      perf_stall_d = perf_stall_q;
    end
    if ((|hit_s) && (perf_fwd_q != 32'hffffffff)) begin
      perf_fwd_d = perf_fwd_q + 32'd1;
    end else begin
      perf_fwd_d = perf_fwd_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_q <= 32'd0;
      perf_fwd_q   <= 32'd0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_fwd_q   <= perf_fwd_d;
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_fwd_cnt   = perf_fwd_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl.
module tb_pipe_hazard_ctrl;
  import pipe_pkg::*;

  localparam int NS = 4;
  localparam int NP = 2;
  localparam int DW = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic             de_valid;
  logic [NP-1:0]    de_rd_en;
  logic [NP*AW-1:0] de_rd_idx;
  logic [NP*DW-1:0] rf_rdata;
  logic [NP*DW-1:0] fwd_rdata;
  logic [NS-1:0]    stg_valid;
  logic [NS*AW-1:0] stg_dest;
  logic [NS*DW-1:0] stg_value;
  logic [NS-1:0]    stg_late;
  logic             de_mc_req;
  logic             de_stall, flush;
  logic             exc_valid, eret_valid, br_valid, fe_valid;
  logic [31:0]      exc_target, eret_target, br_target, fe_pc, nextpc;
`ifdef PIPE_HAZ_PERF_EN
  logic [31:0]      perf_stall_cnt, perf_fwd_cnt;
`endif

  pipe_hazard_ctrl_if mc_bus ();

  pipe_hazard_ctrl #(
    .NUM_STAGES (NS), .NUM_RPORTS (NP), .DATA_W (DW), .REG_AW (AW), .RESET_PC (32'hbfc00000)
  ) dut (
    .clk (clk), .reset (reset), .de_valid (de_valid), .de_rd_en (de_rd_en),
    .de_rd_idx (de_rd_idx), .rf_rdata (rf_rdata), .fwd_rdata (fwd_rdata),
    .stg_valid (stg_valid), .stg_dest (stg_dest), .stg_value (stg_value),
    .stg_late (stg_late), .de_mc_req (de_mc_req), .mc (mc_bus.master),
    .de_stall (de_stall), .flush (flush),
    .exc_valid (exc_valid), .exc_target (exc_target),
    .eret_valid (eret_valid), .eret_target (eret_target),
    .br_valid (br_valid), .br_target (br_target),
    .fe_valid (fe_valid), .fe_pc (fe_pc), .nextpc (nextpc)
`ifdef PIPE_HAZ_PERF_EN
    , .perf_stall_cnt (perf_stall_cnt), .perf_fwd_cnt (perf_fwd_cnt)
`endif
  );

  typedef struct {
    string       tag;
    int          kind;
    logic [31:0] val;
  } exp_t;

  exp_t comb_q[$];
  exp_t reg_q[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic logic [31:0] obs(int kind);
    case (kind)
      0:       return fwd_rdata[31:0];
      1:       return fwd_rdata[63:32];
      2:       return {31'd0, de_stall};
      3:       return {31'd0, mc_bus.mc_valid};
      4:       return {31'd0, mc_bus.mc_discard};
      5:       return {31'd0, flush};
      6:       return nextpc;
      7:       return 32'(dut.state_q);
      default: return 32'hxxxxxxxx;
    endcase
  endfunction

  task automatic compare(input exp_t e);
    logic [31:0] o;
    o = obs(e.kind);
    checks++;
    assert (o === e.val) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", e.tag, o, e.val);
    end
  endtask

  task automatic ec(input string tag, input int kind, input logic [31:0] val);
    exp_t e;
    e.tag = tag; e.kind = kind; e.val = val;
    comb_q.push_back(e);
  endtask

  task automatic er(input string tag, input int kind, input logic [31:0] val);
    exp_t e;
    e.tag = tag; e.kind = kind; e.val = val;
    reg_q.push_back(e);
  endtask

  // Combinational expectations on the falling edge, registered ones just after the rising edge.
  task automatic cycle();
    @(negedge clk);
    while (comb_q.size() > 0) compare(comb_q.pop_front());
    @(posedge clk);
    #1;
    while (reg_q.size() > 0) compare(reg_q.pop_front());
  endtask

  task automatic clear();
    de_valid = 1'b0; de_rd_en = '0; de_rd_idx = '0;
    rf_rdata = {32'h0000bbbb, 32'h0000aaaa};
    stg_valid = '0; stg_dest = '0; stg_value = '0; stg_late = '0;
    de_mc_req = 1'b0; mc_bus.mc_ready = 1'b0; mc_bus.mc_done = 1'b0;
    exc_valid = 1'b0; exc_target = 32'h80000180;
    eret_valid = 1'b0; eret_target = 32'h90000000;
    br_valid = 1'b0; br_target = 32'h00002000;
    fe_valid = 1'b1; fe_pc = 32'h00001000;
  endtask

  task automatic set_stg(input int s, input logic v, input reg_idx_t d,
                         input logic [31:0] val, input logic late);
    stg_valid[s] = v;
    stg_dest[s*AW +: AW] = d;
    stg_value[s*DW +: DW] = val;
    stg_late[s] = late;
  endtask

  initial begin
    reset = 1'b1;
    clear();
    fe_valid = 1'b0;
    ec("rst_stall", 2, 32'd0); ec("rst_mcv", 3, 32'd0); ec("rst_flush", 5, 32'd0);
    ec("rst_disc", 4, 32'd0);
    er("rst_pc", 6, 32'hbfc00000); er("rst_state", 7, 32'(IDLE));
    cycle();
    reset = 1'b0;

    // Youngest-first forwarding.
    clear();
    de_valid = 1'b1; de_rd_en = 2'b11;
    de_rd_idx[0 +: AW] = reg_idx_t'(5); de_rd_idx[AW +: AW] = reg_idx_t'(9);
    set_stg(0, 1'b1, reg_idx_t'(5), 32'h11, 1'b0);
    set_stg(2, 1'b1, reg_idx_t'(5), 32'h22, 1'b0);
    ec("fwd_young", 0, 32'h11); ec("fwd_p1_rf", 1, 32'h0000bbbb); ec("fwd_nostall", 2, 32'd0);
    er("pc_seq", 6, 32'h00001004);
    cycle();
    stg_valid[0] = 1'b0;
    de_rd_idx[AW +: AW] = reg_idx_t'(5);
    ec("fwd_old", 0, 32'h22); ec("fwd_p1_old", 1, 32'h22);
    cycle();

    // Late result stalls; older non-late match ignored; branch blocked by stall.
    clear();
    de_valid = 1'b1; de_rd_en = 2'b01; de_rd_idx[0 +: AW] = reg_idx_t'(5);
    set_stg(0, 1'b1, reg_idx_t'(5), 32'h11, 1'b1);
    set_stg(2, 1'b1, reg_idx_t'(5), 32'h22, 1'b0);
    br_valid = 1'b1;
    ec("late_stall", 2, 32'd1);
    er("br_blocked", 6, 32'h00001004);
    cycle();
    stg_late[0] = 1'b0;
    ec("late_clr_stall", 2, 32'd0); ec("late_clr_fwd", 0, 32'h11);
    er("br_taken", 6, 32'h00002000);
    cycle();
    // r0 never hazards.
    de_rd_idx[0 +: AW] = reg_idx_t'(0);
    set_stg(0, 1'b1, reg_idx_t'(0), 32'h33, 1'b1);
    br_valid = 1'b0;
    ec("r0_stall", 2, 32'd0); ec("r0_fwd", 0, 32'h0000aaaa);
    cycle();

    // Divider issue with mc_ready held low for three cycles.
    clear();
    de_valid = 1'b1; de_mc_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ec("issue_wait_mcv", 3, 32'd1); ec("issue_wait_stall", 2, 32'd1);
      cycle();
    end
    mc_bus.mc_ready = 1'b1;
    ec("issue_hs_mcv", 3, 32'd1); ec("issue_hs_stall", 2, 32'd0);
    er("to_wait", 7, 32'(WAIT));
    cycle();
    de_mc_req = 1'b0; mc_bus.mc_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      ec("wait_mcv", 3, 32'd0); ec("wait_stall", 2, 32'd1);
      cycle();
    end
    mc_bus.mc_done = 1'b1;
    ec("done_stall", 2, 32'd1); ec("done_disc", 4, 32'd0);
    er("done_idle", 7, 32'(IDLE));
    cycle();
    mc_bus.mc_done = 1'b0;
    ec("after_done_stall", 2, 32'd0);
    cycle();

    // Exception while waiting: drain and discard the late result.
    clear();
    de_valid = 1'b1; de_mc_req = 1'b1; mc_bus.mc_ready = 1'b1;
    er("issue2_wait", 7, 32'(WAIT));
    cycle();
    de_mc_req = 1'b0; mc_bus.mc_ready = 1'b0; exc_valid = 1'b1;
    ec("exc_flush", 5, 32'd1); ec("exc_mcv", 3, 32'd0);
    er("to_drain", 7, 32'(DRAIN)); er("exc_pc", 6, 32'h80000180);
    cycle();
    exc_valid = 1'b0;
    ec("drain_stall", 2, 32'd0); ec("drain_disc0", 4, 32'd0);
    cycle();
    de_mc_req = 1'b1;
    ec("drain_req_stall", 2, 32'd1); ec("drain_req_mcv", 3, 32'd0);
    cycle();
    de_mc_req = 1'b0; mc_bus.mc_done = 1'b1;
    ec("drain_discard", 4, 32'd1);
    er("drain_idle", 7, 32'(IDLE));
    cycle();
    mc_bus.mc_done = 1'b0;
    ec("idle_disc", 4, 32'd0);
    cycle();

    // mc_done and flush together in WAIT keep the result.
    de_mc_req = 1'b1; mc_bus.mc_ready = 1'b1;
    er("issue3_wait", 7, 32'(WAIT));
    cycle();
    de_mc_req = 1'b0; mc_bus.mc_ready = 1'b0;
    mc_bus.mc_done = 1'b1; eret_valid = 1'b1;
    ec("done_flush_disc", 4, 32'd0);
    er("done_flush_idle", 7, 32'(IDLE)); er("eret_pc", 6, 32'h90000000);
    cycle();

    // Redirect priority and PC boundaries.
    clear();
    de_valid = 1'b1; de_mc_req = 1'b1; exc_valid = 1'b1; eret_valid = 1'b1;
    ec("flush_mcv", 3, 32'd0); ec("flush_stall", 2, 32'd0);
    er("exc_over_eret", 6, 32'h80000180);
    cycle();
    clear();
    fe_valid = 1'b0;
    er("fe_empty_pc", 6, 32'hbfc00000);
    cycle();
    fe_pc = 32'hfffffffc; fe_valid = 1'b1;
    er("pc_wrap", 6, 32'h00000000);
    cycle();

    // Reset during WAIT.
    clear();
    de_valid = 1'b1; de_mc_req = 1'b1; mc_bus.mc_ready = 1'b1;
    er("issue4_wait", 7, 32'(WAIT));
    cycle();
    clear();
    reset = 1'b1;
    er("rst_wait_state", 7, 32'(IDLE)); er("rst_wait_pc", 6, 32'hbfc00000);
    cycle();
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
